// File: rtl/qu_common.sv
// ---------------------------------------------------------------------------
// qu_common -- shared types for the commit stage and its neighbours.
//   rob_addr_t      : ROB index (the ROB owns pointer arithmetic and wrap)
//   phy_rf_addr_t   : physical register index
//   arch_rf_addr_t  : architectural register index (x0..x31)
//   rob_entry_t     : retirement-relevant fields of a ROB entry
//   commit_state_t  : commit FSM states (RUN, FLUSH)
// ---------------------------------------------------------------------------
package qu_common;

   localparam int ARCH_REGS_DEFAULT   = 32;
   localparam int ARCH_REG_ADDR_WIDTH = 5;
   localparam int PHY_RF_ADDR_WIDTH   = 6;
   localparam int ROB_ADDR_WIDTH      = 5;

   typedef logic [ROB_ADDR_WIDTH-1:0]      rob_addr_t;
   typedef logic [PHY_RF_ADDR_WIDTH-1:0]   phy_rf_addr_t;
   typedef logic [ARCH_REG_ADDR_WIDTH-1:0] arch_rf_addr_t;

   typedef struct packed {
      logic          has_dest;
      arch_rf_addr_t dest_arch;
      phy_rf_addr_t  dest_phy;
      phy_rf_addr_t  old_phy;
      logic          mispredict;
      logic [31:0]   target_pc;
   } rob_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } commit_state_t;

   // An entry updates the RRAT (and frees its old mapping) only when it
   // really writes an architectural register other than x0.
   function automatic logic writes_dest(input rob_entry_t e);
      return e.has_dest && (e.dest_arch != '0);
   endfunction

endpackage

// File: rtl/commit_if.sv
// ---------------------------------------------------------------------------
// commit_if -- ROB head to commit-stage handshake.
//   rob_head_ptr      : head index (informational, owned by the ROB)
//   rob_head_valid    : head entry occupied
//   rob_head_ready    : head result has been written
//   rob_head_entry    : head entry fields
//   rob_incr_head_ptr : combinational pop request back to the ROB
// master = ROB side, slave = commit side.
// ---------------------------------------------------------------------------
interface commit_if;
   import qu_common::*;

   rob_addr_t  rob_head_ptr;
   logic       rob_head_valid;
   logic       rob_head_ready;
   rob_entry_t rob_head_entry;
   logic       rob_incr_head_ptr;

   modport master (
      output rob_head_ptr,
      output rob_head_valid,
      output rob_head_ready,
      output rob_head_entry,
      input  rob_incr_head_ptr
   );

   modport slave (
      input  rob_head_ptr,
      input  rob_head_valid,
      input  rob_head_ready,
      input  rob_head_entry,
      output rob_incr_head_ptr
   );
endinterface

// File: rtl/commit_rrat.sv
// ---------------------------------------------------------------------------
// commit_rrat -- retirement RAT storage.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : write one entry this edge
//   wr_addr   : architectural register to remap
//   wr_data   : new physical register
//   snapshot  : all entries flattened, entry i at [i*W +: W]
// Entry 0 (x0) is a hard zero and has no storage.
// ---------------------------------------------------------------------------
module commit_rrat
   import qu_common::*;
#(
   parameter int ARCH_REGS          = ARCH_REGS_DEFAULT,
   parameter int RRAT_INIT_IDENTITY = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_en,
   input  arch_rf_addr_t                         wr_addr,
   input  phy_rf_addr_t                          wr_data,
   output logic [ARCH_REGS*PHY_RF_ADDR_WIDTH-1:0] snapshot
);

   localparam int W = PHY_RF_ADDR_WIDTH;

   assign snapshot[0 +: W] = '0;

   for (genvar i = 1; i < ARCH_REGS; i++) begin : g_ent
      phy_rf_addr_t ent_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ent_q <= (RRAT_INIT_IDENTITY != 0) ? phy_rf_addr_t'(i) : '0;
         end else if (wr_en && (wr_addr == arch_rf_addr_t'(i))) begin
            ent_q <= wr_data;
         end
      end

      assign snapshot[i*W +: W] = ent_q;
   end

endmodule

// File: rtl/commit.sv
// ---------------------------------------------------------------------------
// commit -- in-order retirement from the ROB head.
//   clk, rst          : clock, asynchronous active-high reset
//   rob (commit_if)   : ROB head handshake, pops via rob_incr_head_ptr
//   free_list_wr_en   : registered, release of the committed old mapping
//   free_list_wr_addr : physical register being released
//   flush, flush_pc   : registered one-cycle redirect after a mispredict
//   rrat_snapshot     : retirement RAT for front-end RAT restore
//   commit_count      : committed-instruction counter, only present when
//                       QU_COMMIT_PERF_CNT_EN is defined
// One instruction commits per cycle at most. A mispredict commit still
// updates RRAT and free list, then spends one FLUSH cycle refusing the head.
// ---------------------------------------------------------------------------
module commit
   import qu_common::*;
#(
   parameter int ARCH_REGS          = ARCH_REGS_DEFAULT,
   parameter int RRAT_INIT_IDENTITY = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   commit_if.slave                               rob,
   output logic                                  free_list_wr_en,
   output phy_rf_addr_t                          free_list_wr_addr,
   output logic                                  flush,
   output logic [31:0]                           flush_pc,
   output logic [ARCH_REGS*PHY_RF_ADDR_WIDTH-1:0] rrat_snapshot
`ifdef QU_COMMIT_PERF_CNT_EN
   ,
   output logic [31:0]                           commit_count
`endif
);

   commit_state_t state_q;
   logic          commit_fire;
   logic          rrat_wr_en;
   logic          unused_head_ptr;

   // The head pointer is only meaningful to the ROB; wrap handling lives there.
   assign unused_head_ptr = ^rob.rob_head_ptr;

   // Pop is combinational so the ROB advances in the commit cycle itself.
   // Reset gates it so a head that looks ready during reset is not lost twice.
   assign commit_fire = (state_q == RUN) && rob.rob_head_valid &&
                        rob.rob_head_ready && !rst;
   assign rob.rob_incr_head_ptr = commit_fire;
   assign rrat_wr_en = commit_fire && writes_dest(rob.rob_head_entry);

   commit_rrat #(
      .ARCH_REGS          (ARCH_REGS),
      .RRAT_INIT_IDENTITY (RRAT_INIT_IDENTITY)
   ) u_rrat (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (rrat_wr_en),
      .wr_addr  (rob.rob_head_entry.dest_arch),
      .wr_data  (rob.rob_head_entry.dest_phy),
      .snapshot (rrat_snapshot)
   );

   // Commit FSM and its registered side effects (free, flush).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= RUN;
         free_list_wr_en   <= 1'b0;
         free_list_wr_addr <= '0;
         flush             <= 1'b0;
         flush_pc          <= '0;
      end else begin
         case (state_q)
            RUN: begin
               free_list_wr_en <= rrat_wr_en;
               if (rrat_wr_en) begin
                  free_list_wr_addr <= rob.rob_head_entry.old_phy;
               end
               if (commit_fire && rob.rob_head_entry.mispredict) begin
                  state_q  <= FLUSH;
                  flush    <= 1'b1;
                  flush_pc <= rob.rob_head_entry.target_pc;
               end else begin
                  flush <= 1'b0;
               end
            end
            FLUSH: begin
               state_q         <= RUN;
               free_list_wr_en <= 1'b0;
               flush           <= 1'b0;
            end
            default: begin
               state_q         <= RUN;
               free_list_wr_en <= 1'b0;
               flush           <= 1'b0;
            end
         endcase
      end
   end

`ifdef QU_COMMIT_PERF_CNT_EN
   // Free-running commit counter, wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_count <= '0;
      end else if (commit_fire) begin
         commit_count <= commit_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_commit.sv
// ---------------------------------------------------------------------------
// tb_commit -- bench for the commit stage: directed vector table, a few
// multi-cycle reset sequences, then random heads against a reference model.
// ---------------------------------------------------------------------------
module tb_commit;
   import qu_common::*;

   localparam int AR = ARCH_REGS_DEFAULT;
   localparam int W  = PHY_RF_ADDR_WIDTH;

   logic                clk;
   logic                rst;
   logic                free_list_wr_en;
   phy_rf_addr_t        free_list_wr_addr;
   logic                flush;
   logic [31:0]         flush_pc;
   logic [AR*W-1:0]     rrat_snapshot;
`ifdef QU_COMMIT_PERF_CNT_EN
   logic [31:0]         commit_count;
`endif

   commit_if rob_if ();

   commit #(.ARCH_REGS(AR), .RRAT_INIT_IDENTITY(1)) dut (
      .clk               (clk),
      .rst               (rst),
      .rob               (rob_if),
      .free_list_wr_en   (free_list_wr_en),
      .free_list_wr_addr (free_list_wr_addr),
      .flush             (flush),
      .flush_pc          (flush_pc),
      .rrat_snapshot     (rrat_snapshot)
`ifdef QU_COMMIT_PERF_CNT_EN
      ,
      .commit_count      (commit_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int unsigned  m_rrat [AR];
   bit           m_in_flush;
   bit           m_pop;
   bit           m_fen;
   logic [5:0]   m_faddr;
   bit           m_flush;
   logic [31:0]  m_fpc;
   int unsigned  m_count;

   // Sampled DUT values from the last cycle
   logic         s_pop, s_fen, s_flush;
   logic [5:0]   s_faddr;
   logic [31:0]  s_fpc;

   typedef struct {
      logic        v, r, hd;
      logic [4:0]  arch;
      logic [5:0]  phy, old;
      logic        mp;
      logic [31:0] pc;
      logic        e_pop, e_fen;
      logic [5:0]  e_faddr;
      logic        e_flush;
      logic [31:0] e_fpc;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(logic v, logic r, logic hd, logic [4:0] arch,
                               logic [5:0] phy, logic [5:0] old, logic mp,
                               logic [31:0] pc, logic e_pop, logic e_fen,
                               logic [5:0] e_faddr, logic e_flush,
                               logic [31:0] e_fpc);
      vec_t t;
      t.v = v; t.r = r; t.hd = hd; t.arch = arch; t.phy = phy; t.old = old;
      t.mp = mp; t.pc = pc; t.e_pop = e_pop; t.e_fen = e_fen;
      t.e_faddr = e_faddr; t.e_flush = e_flush; t.e_fpc = e_fpc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rrat_at(input int i);
      return rrat_snapshot[i*W +: W];
   endfunction

   task automatic chk_snap(input string name);
      logic [AR*W-1:0] exp;
      for (int i = 0; i < AR; i++) exp[i*W +: W] = W'(m_rrat[i]);
      checks++;
      if (rrat_snapshot !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, rrat_snapshot, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < AR; i++) m_rrat[i] = i;
      m_rrat[0] = 0;
      m_in_flush = 0; m_fen = 0; m_faddr = '0; m_flush = 0; m_fpc = '0;
      m_count = 0;
   endtask

   task automatic drive(input logic v, input logic r, input logic hd,
                        input logic [4:0] arch, input logic [5:0] phy,
                        input logic [5:0] old, input logic mp, input logic [31:0] pc);
      rob_if.rob_head_valid            = v;
      rob_if.rob_head_ready            = r;
      rob_if.rob_head_entry.has_dest   = hd;
      rob_if.rob_head_entry.dest_arch  = arch;
      rob_if.rob_head_entry.dest_phy   = phy;
      rob_if.rob_head_entry.old_phy    = old;
      rob_if.rob_head_entry.mispredict = mp;
      rob_if.rob_head_entry.target_pc  = pc;
   endtask

   // Called at posedge+1 with inputs already driven. Samples the pop
   // mid-cycle, crosses one edge, samples registered outputs, advances model.
   task automatic cycle();
      rob_entry_t e;
      e = rob_if.rob_head_entry;
      m_pop = !m_in_flush && rob_if.rob_head_valid && rob_if.rob_head_ready;
      #4;
      s_pop = rob_if.rob_incr_head_ptr;
      @(posedge clk);
      #1;
      s_fen = free_list_wr_en; s_faddr = free_list_wr_addr;
      s_flush = flush; s_fpc = flush_pc;
      m_fen = m_pop && e.has_dest && (e.dest_arch != 0);
      if (m_fen) begin
         m_rrat[e.dest_arch] = e.dest_phy;
         m_faddr = e.old_phy;
      end
      m_flush = m_pop && e.mispredict;
      if (m_flush) m_fpc = e.target_pc;
      m_in_flush = m_flush;
      if (m_pop) begin
         m_count++;
         rob_if.rob_head_ptr = rob_if.rob_head_ptr + 1'b1;
      end
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_vec(input int k);
      vec_t t;
      t = tbl[k];
      drive(t.v, t.r, t.hd, t.arch, t.phy, t.old, t.mp, t.pc);
      cycle();
      chk($sformatf("vec%0d pop", k), 32'(s_pop), 32'(t.e_pop));
      chk($sformatf("vec%0d free_en", k), 32'(s_fen), 32'(t.e_fen));
      if (t.e_fen) chk($sformatf("vec%0d free_addr", k), 32'(s_faddr), 32'(t.e_faddr));
      chk($sformatf("vec%0d flush", k), 32'(s_flush), 32'(t.e_flush));
      if (t.e_flush) chk($sformatf("vec%0d flush_pc", k), s_fpc, t.e_fpc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = mk(1,1,1, 5,40, 5,0,32'h0,   1,1, 5,0,32'h0);
      tbl[1]  = mk(1,1,1, 0,41, 7,0,32'h0,   1,0, 0,0,32'h0);
      tbl[2]  = mk(1,0,1, 6,42, 6,0,32'h0,   0,0, 0,0,32'h0);
      tbl[3]  = mk(1,0,1, 6,42, 6,0,32'h0,   0,0, 0,0,32'h0);
      tbl[4]  = mk(1,0,1, 6,42, 6,0,32'h0,   0,0, 0,0,32'h0);
      tbl[5]  = mk(1,1,1, 7,44, 7,0,32'h0,   1,1, 7,0,32'h0);
      tbl[6]  = mk(0,1,1, 8,43, 8,0,32'h0,   0,0, 0,0,32'h0);
      tbl[7]  = mk(1,1,1, 9,45, 9,1,32'h100, 1,1, 9,1,32'h100);
      tbl[8]  = mk(1,1,1,10,46,10,0,32'h0,   0,0, 0,0,32'h0);
      tbl[9]  = mk(1,1,1,10,46,10,0,32'h0,   1,1,10,0,32'h0);
      tbl[10] = mk(1,1,1, 3,50, 3,0,32'h0,   1,1, 3,0,32'h0);
      tbl[11] = mk(1,1,1, 3,51,50,0,32'h0,   1,1,50,0,32'h0);
      tbl[12] = mk(1,1,1, 3,52,51,0,32'h0,   1,1,51,0,32'h0);
      tbl[13] = mk(1,1,1, 3,53,52,0,32'h0,   1,1,52,0,32'h0);

      rob_if.rob_head_ptr = '0;
      drive(1, 1, 1, 5, 60, 5, 0, 0);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("pop held low in reset", 32'(rob_if.rob_incr_head_ptr), 32'd0);
      chk("free_en in reset", 32'(free_list_wr_en), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #4;
      // Reset release
      chk_snap("reset identity rrat");
      chk("reset flush", 32'(flush), 32'd0);
      chk("reset flush_pc", flush_pc, 32'd0);
      chk("reset free_addr", 32'(free_list_wr_addr), 32'd0);
`ifdef QU_COMMIT_PERF_CNT_EN
      chk("reset commit_count", commit_count, 32'd0);
`endif
      @(posedge clk);
      #1;

      // Directed vector table
      for (int k = 0; k < 14; k++) run_vec(k);
      chk("rrat[5] after single", 32'(rrat_at(5)), 32'd40);
      chk("rrat[0] stays zero", 32'(rrat_at(0)), 32'd0);
      chk("rrat[3] after burst", 32'(rrat_at(3)), 32'd53);
      chk_snap("rrat after table");

      // Back-to-back commits from a fresh reset, with counter
      do_reset();
      for (int k = 10; k < 14; k++) run_vec(k);
      chk("rrat[3] back-to-back", 32'(rrat_at(3)), 32'd53);
`ifdef QU_COMMIT_PERF_CNT_EN
      chk("commit_count after 4", commit_count, 32'd4);
`endif

      // Reset asserted during the FLUSH cycle aborts the flush at once
      run_vec(7);
      drive(1, 1, 1, 11, 47, 11, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      chk("flush dropped by async reset", 32'(flush), 32'd0);
      chk("no pop while reset", 32'(rob_if.rob_incr_head_ptr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk_snap("rrat after mid-flush reset");

      // A commit in the cycle reset asserts is lost
      drive(1, 1, 1, 5, 60, 5, 0, 0);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      chk("lost commit rrat[5]", 32'(rrat_at(5)), 32'd5);
      chk("lost commit free_en", 32'(free_list_wr_en), 32'd0);
      @(posedge clk);
      #1;

      // Randomized heads against the model
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
               5'($urandom), 6'($urandom), 6'($urandom), $urandom_range(7) == 0,
               $urandom);
         cycle();
         chk("rand pop", 32'(s_pop), 32'(m_pop));
         chk("rand free_en", 32'(s_fen), 32'(m_fen));
         if (m_fen) chk("rand free_addr", 32'(s_faddr), 32'(m_faddr));
         chk("rand flush", 32'(s_flush), 32'(m_flush));
         if (m_flush) chk("rand flush_pc", s_fpc, m_fpc);
         if ((n % 16) == 15) chk_snap("rand rrat");
      end
      chk_snap("rand rrat final");
`ifdef QU_COMMIT_PERF_CNT_EN
      chk("rand commit_count", commit_count, 32'(m_count));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit.md
COMMIT -- requirements
Module: commit

Interface
REQ-001 Parameter ARCH_REGS, default 32, number of architectural registers (x0 included).
REQ-002 Parameter RRAT_INIT_IDENTITY, default 1, a value of 1 resets RRAT entry i to physical register i.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rob_head_ptr  in  rob_addr_t  ROB head index, owned by the ROB.
REQ-006 rob_head_valid  in  1  head entry occupied.
REQ-007 rob_head_ready  in  1  head result written by retire.
REQ-008 rob_head_entry  in  rob_entry_t  fields: has_dest, dest_arch (5b), dest_phy, old_phy, mispredict, target_pc (32b).
REQ-009 rob_incr_head_ptr  out  1  combinational pulse that pops the head.
REQ-010 free_list_wr_en  out  1  registered, releases one physical register.
REQ-011 free_list_wr_addr  out  phy_rf_addr_t  register being released.
REQ-012 flush  out  1  registered, one-cycle pipeline flush.
REQ-013 flush_pc  out  32  redirect PC, valid while flush=1.
REQ-014 rrat_snapshot  out  ARCH_REGS*PHY_RF_ADDR_WIDTH  retirement RAT contents, for front-end RAT restore.
REQ-015 commit_count  out  32  committed-instruction count, present only with QU_COMMIT_PERF_CNT_EN.

Function
REQ-016 Two-state FSM: RUN, FLUSH.
REQ-017 In RUN, the head commits in cycle N when rob_head_valid and rob_head_ready are both 1.
- rob_incr_head_ptr=1 in cycle N.
- At most one commit per cycle.
REQ-018 On commit with has_dest=1 and dest_arch!=0:
- RRAT[dest_arch]<=dest_phy at edge N.
- free_list_wr_en=1 and free_list_wr_addr=old_phy in cycle N+1.
REQ-019 On commit with has_dest=0 or dest_arch=0: no RRAT write, and free_list_wr_en stays 0 in N+1.
REQ-020 On commit with mispredict=1:
- RRAT and free-list effects apply as normal.
- The FSM moves to FLUSH at edge N.
- flush=1 and flush_pc=target_pc in cycle N+1.
REQ-021 FLUSH lasts exactly one cycle.
- rob_incr_head_ptr is forced to 0 and head inputs are ignored.
- Next state is RUN.
- rrat_snapshot already includes the mispredicted instruction's update.
REQ-022 If the head is not ready, or the ROB is empty, nothing commits: no pointer pop, no RRAT change, no free.
REQ-023 Head-pointer wrap-around is handled entirely by the ROB; commit never compares pointers.
REQ-024 RRAT entry 0 always reads 0.
REQ-025 RRAT updates from back-to-back commits take effect in program order, one per edge.

Reset
REQ-026 While rst=1:
- FSM=RUN.
- flush=0, flush_pc=0, free_list_wr_en=0, free_list_wr_addr=0, rob_incr_head_ptr=0.
- RRAT[i]=i when RRAT_INIT_IDENTITY=1, else 0.
- commit_count=0.
REQ-027 Reset asserted mid-FLUSH aborts the flush: flush drops to 0 immediately (asynchronous reset).
REQ-028 A commit occurring in the cycle in which reset asserts is lost.

Configuration
REQ-029 Macro QU_COMMIT_PERF_CNT_EN defined:
- commit_count increments by 1 at every commit edge.
- It wraps from 0xFFFFFFFF to 0.
REQ-030 Macro QU_COMMIT_PERF_CNT_EN undefined: the commit_count port and its counter logic are absent.

Structure
REQ-031 rob_entry_t, rob_addr_t, phy_rf_addr_t and ARCH_REGS_DEFAULT SHALL live in qu_common.
REQ-032 commit_state_t (RUN, FLUSH) SHALL live in qu_common.
REQ-033 Sub-module commit_rrat SHALL hold the RRAT register array, with one write port and the flattened snapshot output.

Verification
REQ-034 Reset release check: rrat_snapshot shows identity mapping; flush=0; commit_count=0.
REQ-035 Single commit:
- Stimulus: head valid/ready, has_dest=1, dest_arch=5, dest_phy=40, old_phy=5.
- Response: rob_incr_head_ptr=1 in the same cycle; RRAT[5]=40; next cycle free_list_wr_en=1 with addr 5.
REQ-036 x0 destination:
- Stimulus: commit with dest_arch=0, dest_phy=41.
- Response: RRAT[0] stays 0; no free.
REQ-037 Head not ready:
- Stimulus: rob_head_valid=1, rob_head_ready=0 for 3 cycles, then ready.
- Response: no pop for 3 cycles; exactly one pop after ready.
REQ-038 Mispredict:
- Stimulus: commit with mispredict=1, target_pc=0x100, and the next head already ready.
- Response: next cycle flush=1, flush_pc=0x100, no pop; the following cycle pops the next head.
REQ-039 Back-to-back and counter:
- Stimulus: 4 consecutive commits to dest_arch=3 with dest_phy 50..53.
- Response: RRAT[3]=53; frees 3,50,51,52 in order; commit_count=4 when the macro is defined.
